instr_fetch: RTL
================

Name: instr_fetch

Overview:
Instruction fetch stage that sits directly upstream of the instruction ROM.
- Holds the program counter and drives the ROM word address.
- Absorbs the ROM's one-cycle synchronous read latency.
- Delivers {pc, instruction} pairs to decode over a valid/ready handshake.
- A 2-entry buffer guarantees no response is lost under backpressure; a redirect port (branch/exception) flushes in-flight work.

Parameters:
- RESET_PC, 32'h0000_0000: byte address of the first fetch after reset.
- ROM_AW, 8: ROM word-address width; rom_addr = pc[ROM_AW+1:2].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rom_addr  out  ROM_AW  word address to ROM; ROM returns mem[rom_addr] on rom_data one cycle later.
- rom_data  in  32  registered ROM read data.
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  in  32  byte target; bits [1:0] ignored (treated as 0).
- out_valid  out  1  out_instr/out_pc valid.
- out_ready  in  1  decode accepts this cycle.
- out_instr  out  32  fetched instruction.
- out_pc  out  32  byte address of out_instr.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; inflight=0; buffer empty.
  - out_valid=0, out_instr=0, out_pc=0.
  - rom_addr=RESET_PC[ROM_AW+1:2].
- Terms:
  - pop = out_valid & out_ready & ~redirect_valid.
  - issue = redirect_valid | (count + inflight - pop < 2), where count is buffer occupancy 0..2.
- Address mux (combinational): rom_addr = redirect_valid ? redirect_pc[ROM_AW+1:2] : pc[ROM_AW+1:2].
- On issue:
  - inflight<=1; inflight_pc<=issued pc.
  - pc<=issued pc+4 (32-bit wrap; ROM index wraps mod 2^ROM_AW naturally).
- Without issue: inflight<=0; pc held.
- Response: if inflight=1 in cycle N, rom_data in cycle N is written to the buffer as {inflight_pc, rom_data}.
  - The credit rule guarantees space; overflow is impossible and is asserted in simulation.
- Buffer: 2-entry FIFO; the head drives out_* registered. out_valid = (count!=0).
- Outputs held stable while out_valid & ~out_ready.
- Latency:
  - Request in cycle N: data in the buffer at the N+1 edge; out_valid in cycle N+2.
  - First instruction after reset release: out_valid on the 2nd rising edge.
- Throughput: 1 instruction/cycle with out_ready held high.
- Stall: out_ready=0 stops issue once count+inflight=2; the in-flight response is still captured; no duplicate or dropped pcs.
- Redirect (priority over everything):
  - Same cycle: buffer flushed; the pending in-flight response, arriving next cycle, is discarded; pop is not counted.
  - Request for redirect_pc issued the same cycle; pc<=redirect_pc+4.
  - out_valid=0 in cycle R+1; target instruction has out_valid in cycle R+2.
- Back-to-back redirects: the last one wins; each flushes the previous.
- Reset mid-operation: immediate return to reset state; any in-flight response is dropped.

Decomposition:
- fetch_pkg:
  - PC_W=32, INSTR_W=32, default RESET_PC, FETCH_BUF_DEPTH=2.
  - Typedef fetch_entry_t {pc[31:0], instr[31:0]}.
- Sub-module fetch_buf:
  - 2-entry synchronous FIFO of fetch_entry_t with push, pop, flush and count.
  - Async active-low reset, same clk/rst_n naming.
- Top holds pc, inflight tracking, the credit/issue logic and the address mux.

Test Plan:
1. Reset release with ROM mem[i]=32'hE000_0000+i, out_ready=1 -> out_valid rises on the 2nd edge; out_pc=0,4,8,… and out_instr=E0000000,E0000001,… every cycle, no gaps.
2. Stall: out_ready=0 for 5 cycles starting after pc 0x8 is accepted -> out_pc holds 0xC with out_instr stable; rom_addr stops advancing after 2 outstanding; on release, the sequence resumes 0xC,0x10,… without loss or duplication.
3. Redirect to 0x40 while the buffer is full and a fetch is in flight -> out_valid=0 next cycle; 2 cycles later out_pc=0x40, out_instr=mem[16]; no stale pc ever appears.
4. Redirect asserted in the same cycle as an out_valid&out_ready handshake, plus back-to-back redirects to 0x80 then 0x100 -> only 0x100 stream emerges; redirect_pc=0x103 behaves as 0x100.
5. Wrap: redirect to 0x3F8 -> out_pc 0x3F8,0x3FC,0x400 with instr mem[254],mem[255],mem[0].
6. rst_n asserted mid-stream with random out_ready -> outputs zero immediately; after release the fetch restarts at RESET_PC; the in-flight response before reset is never emitted.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch stage.
//   PC_W / INSTR_W     : program-counter and instruction widths
//   DEFAULT_RESET_PC   : default byte address of the first fetch after reset
//   FETCH_BUF_DEPTH    : number of {pc, instr} entries the response buffer holds
//   fetch_entry_t      : one fetched instruction tagged with its byte address
//   align_pc()         : forces a byte address onto a word boundary
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int PC_W            = 32;
  localparam int INSTR_W         = 32;
  localparam int FETCH_BUF_DEPTH = 2;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Redirect targets may carry junk in the byte-offset bits; masking keeps
  // every bit of the input live so nothing is silently truncated.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// -----------------------------------------------------------------------------
// fetch_buf
// Two-entry synchronous FIFO of fetch_entry_t. Entry 0 is always the head, so
// the head value comes straight from a register and stays stable until popped.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   push        : write push_data this cycle
//   push_data   : {pc, instr} entry to store
//   pop         : remove the head this cycle (only legal when count != 0)
//   flush       : discard all contents; wins over push and pop
//   head        : oldest stored entry (zero after reset)
//   count       : current occupancy, 0..2
// -----------------------------------------------------------------------------
module fetch_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t entry0_q, entry0_d;
  fetch_entry_t entry1_q, entry1_d;
  logic [1:0]   count_q,  count_d;

  // Shift-style update: a pop moves entry 1 down into the head slot, and a
  // push lands in the first slot that is free after any pop this cycle.
  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            entry0_d = push_data;
          end else begin
            entry1_d = push_data;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          entry0_d = entry1_q;
          count_d  = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            entry0_d = entry1_q;
            entry1_d = push_data;
          end else begin
            entry0_d = push_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
    end
  end

  assign head  = entry0_q;
  assign count = count_q;

  // The issue credit upstream must never let the buffer overflow or underflow.
  overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !flush && (count_q == 2'd2)));
  underflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && !flush && (count_q == 2'd0)));

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetch stage in front of a synchronous instruction ROM. Keeps the program
// counter, issues one word read per cycle while buffer credit allows, tags
// each ROM response with its pc and hands {pc, instr} to decode through a
// valid/ready handshake. A redirect flushes everything and restarts fetch.
// Ports:
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   rom_addr        : ROM word address; data returns on rom_data next cycle
//   rom_data        : registered ROM read data
//   redirect_valid  : one-cycle pulse, restart fetch at redirect_pc
//   redirect_pc     : byte target, bits [1:0] ignored
//   out_valid       : out_instr / out_pc hold a fetched instruction
//   out_ready       : decode accepts this cycle
//   out_instr       : fetched instruction
//   out_pc          : byte address of out_instr
// -----------------------------------------------------------------------------
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          ROM_AW   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;

  logic [PC_W-1:0] issue_pc;
  logic            issue;
  logic            pop;
  logic            push;
  logic [1:0]      count;
  logic [2:0]      occupancy;
  fetch_entry_t    push_data;
  fetch_entry_t    head;

  assign out_valid = (count != 2'd0);

  // A redirect flushes the buffer, so a handshake in the same cycle is void.
  assign pop = out_valid & out_ready & ~redirect_valid;

  // Slots already spoken for once this cycle's pop retires: stored entries
  // plus the response still on its way from the ROM.
  assign occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = redirect_valid | (occupancy < 3'(FETCH_BUF_DEPTH));

  assign issue_pc = redirect_valid ? align_pc(redirect_pc) : pc_q;
  assign rom_addr = issue_pc[ROM_AW+1:2];

  // The response arriving during a redirect belongs to the old path.
  assign push           = inflight_q & ~redirect_valid;
  assign push_data.pc    = inflight_pc_q;
  assign push_data.instr = rom_data;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = issue_pc;
      pc_d          = issue_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_buf u_fetch_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count)
  );

  assign out_pc    = head.pc;
  assign out_instr = head.instr;

endmodule
